// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and
// the default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single 1-bit full adder cell; the only arithmetic element of the serial adder.
module full_adder (
  input  logic X,
  input  logic Y,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = X ^ Y ^ Cin;
  assign Cout = (X & Y) | (Cin & (X ^ Y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: captures two WIDTH-bit operands and a carry-in,
// then adds them LSB first through one full_adder cell over WIDTH cycles.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic [WIDTH-1:0]   sum_next;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               fa_sum;
  logic               fa_cout;
  logic               last;

  full_adder u_fa (
    .X   (a_sh[0]),
    .Y   (b_sh[0]),
    .Cin (carry),
    .Sum (fa_sum),
    .Cout(fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign sum_next = fa_sum;
    end else begin : g_wide
      assign sum_next = {fa_sum, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          carry  <= fa_cout;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            sum  <= sum_next;
            cout <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
